bypass_fifo: RTL



---
 rtl/bypass_fifo_pkg.sv | 21 ++
 rtl/bypass_fifo_storage.sv | 46 ++++
 rtl/bypass_fifo.sv | 93 +++++++++
 3 files changed

// File: rtl/bypass_fifo_pkg.sv
// Shared constants and helpers for the bypass FIFO.
// Default geometry, count width and pointer wrap helpers.
package bypass_fifo_pkg;

  localparam int DEF_DEPTH = 4;
  localparam int DEF_WIDTH = 4;

  function automatic int count_width(int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_width(int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Wrap at depth-1 so non power-of-two depths work.
  function automatic int ptr_inc(int ptr, int depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/bypass_fifo_storage.sv
// Register array: one write port, one async read port.
// Ports: clk, we/waddr/wdata, raddr/rdata; with BYPASS_FIFO_SNAPSHOT_EN also cnt, snap_data.
module bypass_fifo_storage
  import bypass_fifo_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int WIDTH = DEF_WIDTH,
  parameter int AW    = ptr_width(DEF_DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
`ifdef BYPASS_FIFO_SNAPSHOT_EN
  ,
  input  logic [count_width(DEPTH)-1:0] cnt,
  output logic [WIDTH*DEPTH-1:0]        snap_data
`endif
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  assign rdata = r_mem[raddr];

`ifdef BYPASS_FIFO_SNAPSHOT_EN
  // Slot k is the entry k places behind the read pointer.
  always_comb begin
    int idx;
    idx = 0;
    snap_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = int'(raddr) + k;
      if (idx >= DEPTH) idx = idx - DEPTH;
      if (k < int'(cnt))
        snap_data[k*WIDTH +: WIDTH] = r_mem[AW'(idx)];
    end
  end
`endif

endmodule

// File: rtl/bypass_fifo.sv
// Valid/ready FIFO with zero-latency bypass when empty.
// Ports: clk, rst, in_*, out_*, count; snap_data if BYPASS_FIFO_SNAPSHOT_EN.
module bypass_fifo
  import bypass_fifo_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH-1:0]              out_data,
  output logic [count_width(DEPTH)-1:0] count
`ifdef BYPASS_FIFO_SNAPSHOT_EN
  ,
  output logic [WIDTH*DEPTH-1:0]        snap_data
`endif
);

  localparam int CW = count_width(DEPTH);
  localparam int AW = ptr_width(DEPTH);
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic             w_empty;
  logic             w_full;
  logic             w_accept;
  logic             w_deliver;
  logic             w_bypass;
  logic             w_push;
  logic             w_pop;
  logic [WIDTH-1:0] w_rdata;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == FULL_C);

  // in_ready depends on state and rst only, never on out_ready.
  assign in_ready  = !rst && !w_full;
  assign out_valid = !rst && (!w_empty || in_valid);
  assign out_data  = w_empty ? in_data : w_rdata;

  assign w_accept  = in_valid && in_ready;
  assign w_deliver = out_valid && out_ready;
  assign w_bypass  = w_empty && w_accept && out_ready;
  assign w_push    = w_accept && !w_bypass;
  assign w_pop     = w_deliver && !w_empty;

  assign count     = r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push)
        r_wr_ptr <= AW'(ptr_inc(int'(r_wr_ptr), DEPTH));
      if (w_pop)
        r_rd_ptr <= AW'(ptr_inc(int'(r_rd_ptr), DEPTH));
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  bypass_fifo_storage #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_storage (
    .clk       (clk),
    .we        (w_push),
    .waddr     (r_wr_ptr),
    .wdata     (in_data),
    .raddr     (r_rd_ptr),
    .rdata     (w_rdata)
`ifdef BYPASS_FIFO_SNAPSHOT_EN
    ,
    .cnt       (r_count),
    .snap_data (snap_data)
`endif
  );

endmodule
